// File: rtl/regfile_pred_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pred_pkg
// Shared constants for the predicated register file: data width, register
// count, address width and the hard-wired zero register index, plus a small
// helper that decides whether a write port hits a given read address.
//
// Optional feature macro used by the design: REGFILE_BYPASS_EN
// ---------------------------------------------------------------------------
package regfile_pred_pkg;

   localparam int XLEN  = 32;
   localparam int AW    = 4;
   localparam int NREGS = 16;

   localparam logic [AW-1:0] R0_IDX = '0;

   // True when an active write targets addr and that target is a real
   // (writable) register; r0 never takes part in forwarding or clearing.
   function automatic logic wr_hits(input logic          en,
                                    input logic [AW-1:0] wr_addr,
                                    input logic [AW-1:0] addr);
      return en && (wr_addr == addr) && (wr_addr != R0_IDX);
   endfunction

endpackage

// File: rtl/regfile_pred_if.sv
// ---------------------------------------------------------------------------
// regfile_pred_if
// Bundles the decode/writeback side of the register file.
//   master : decode + writeback stage (drives addresses, claims, writes)
//   slave  : register file (returns values, busy and claim acceptance)
// Signals:
//   pred_addr / pred_value / pred_busy   predicate register read
//   rs_addr / rs_value, rt_addr / rt_value operand reads
//   claim_valid / claim_addr / claim_ready destination reservation
//   wr_en / wr_addr / wr_data             writeback port
// ---------------------------------------------------------------------------
interface regfile_pred_if
   import regfile_pred_pkg::*;
#(
   parameter int XLEN = regfile_pred_pkg::XLEN
);

   logic [AW-1:0]   pred_addr;
   logic [XLEN-1:0] pred_value;
   logic            pred_busy;

   logic [AW-1:0]   rs_addr;
   logic [XLEN-1:0] rs_value;
   logic [AW-1:0]   rt_addr;
   logic [XLEN-1:0] rt_value;

   logic            claim_valid;
   logic [AW-1:0]   claim_addr;
   logic            claim_ready;

   logic            wr_en;
   logic [AW-1:0]   wr_addr;
   logic [XLEN-1:0] wr_data;

   modport master (
      output pred_addr, rs_addr, rt_addr,
      output claim_valid, claim_addr,
      output wr_en, wr_addr, wr_data,
      input  pred_value, pred_busy, rs_value, rt_value, claim_ready
   );

   modport slave (
      input  pred_addr, rs_addr, rt_addr,
      input  claim_valid, claim_addr,
      input  wr_en, wr_addr, wr_data,
      output pred_value, pred_busy, rs_value, rt_value, claim_ready
   );

endinterface

// File: rtl/regfile_pred_scoreboard.sv
// ---------------------------------------------------------------------------
// reg_scoreboard
// One busy bit per register. A set marks a register as having an
// outstanding write claim, a clear retires it. When both target the same
// register in one cycle the set wins, so the newer claim is not lost.
// r0 is never busy.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   set_en_i/addr_i    accepted claim
//   clr_en_i/addr_i    retiring write
//   busy_o             current busy vector (bit per register)
// ---------------------------------------------------------------------------
module reg_scoreboard
   import regfile_pred_pkg::*;
#(
   parameter int NREGS = regfile_pred_pkg::NREGS
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             set_en_i,
   input  logic [AW-1:0]    set_addr_i,
   input  logic             clr_en_i,
   input  logic [AW-1:0]    clr_addr_i,
   output logic [NREGS-1:0] busy_o
);

   logic [NREGS-1:0] busy_q;
   logic [NREGS-1:0] busy_d;

   generate
      for (genvar gi = 0; gi < NREGS; gi++) begin : g_busy
         if (gi == 0) begin : g_r0
            assign busy_d[gi] = 1'b0;
         end else begin : g_rn
            logic set_hit;
            logic clr_hit;
            assign set_hit    = set_en_i && (set_addr_i == AW'(gi));
            assign clr_hit    = clr_en_i && (clr_addr_i == AW'(gi));
            // Claim has priority over a same-cycle clear.
            assign busy_d[gi] = set_hit | (busy_q[gi] & ~clr_hit);
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   assign busy_o = busy_q;

endmodule

// File: rtl/regfile_pred.sv
// ---------------------------------------------------------------------------
// regfile_pred
// 16 x XLEN register file with a predicate read port, two operand read
// ports, one writeback port and a per-register busy scoreboard used by
// decode to reserve destinations (WAW stall when already reserved).
// r0 reads as zero, ignores writes and is never busy.
//
// Optional feature (macro REGFILE_BYPASS_EN): write data is forwarded to
// the read ports, and the predicate busy flag drops, in the cycle of the
// write itself. Without it, reads see the new value one cycle later.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    regfile_pred_if.slave (read, claim and writeback signals)
// ---------------------------------------------------------------------------
module regfile_pred
   import regfile_pred_pkg::*;
#(
   parameter int XLEN  = regfile_pred_pkg::XLEN,
   parameter int NREGS = regfile_pred_pkg::NREGS
) (
   input  logic           clk,
   input  logic           rst_n,
   regfile_pred_if.slave  bus
);

   logic [XLEN-1:0]  regs_q [NREGS];
   logic [NREGS-1:0] busy;

   logic wr_act;
   logic claim_ready;
   logic claim_fire;

   // An in-flight write is discarded while reset is asserted, so it must
   // not be forwarded or used to release a claim either.
   assign wr_act = rst_n && bus.wr_en;

   // -----------------------------------------------------------------------
   // Storage. r0 is reset and never written, so it stays zero.
   // -----------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= '0;
         end
      end else if (bus.wr_en && (bus.wr_addr != R0_IDX)) begin
         regs_q[bus.wr_addr] <= bus.wr_data;
      end
   end

   // -----------------------------------------------------------------------
   // Busy tracking
   // -----------------------------------------------------------------------
   // A reserved destination may be re-claimed in the same cycle its
   // pending write retires; the scoreboard then keeps the bit set.
   assign claim_ready = (bus.claim_addr == R0_IDX)
                     || !busy[bus.claim_addr]
                     || wr_hits(wr_act, bus.wr_addr, bus.claim_addr);

   assign claim_fire = bus.claim_valid && claim_ready;

   reg_scoreboard #(
      .NREGS (NREGS)
   ) u_scoreboard (
      .clk        (clk),
      .rst_n      (rst_n),
      .set_en_i   (claim_fire),
      .set_addr_i (bus.claim_addr),
      .clr_en_i   (wr_act && (bus.wr_addr != R0_IDX)),
      .clr_addr_i (bus.wr_addr),
      .busy_o     (busy)
   );

   assign bus.claim_ready = claim_ready;

   // -----------------------------------------------------------------------
   // Read ports
   // -----------------------------------------------------------------------
   always_comb begin
      bus.pred_value = regs_q[bus.pred_addr];
      bus.rs_value   = regs_q[bus.rs_addr];
      bus.rt_value   = regs_q[bus.rt_addr];
      bus.pred_busy  = busy[bus.pred_addr];
`ifdef REGFILE_BYPASS_EN
      if (wr_hits(wr_act, bus.wr_addr, bus.pred_addr)) begin
         bus.pred_value = bus.wr_data;
         bus.pred_busy  = 1'b0;
      end
      if (wr_hits(wr_act, bus.wr_addr, bus.rs_addr)) begin
         bus.rs_value = bus.wr_data;
      end
      if (wr_hits(wr_act, bus.wr_addr, bus.rt_addr)) begin
         bus.rt_value = bus.wr_data;
      end
`endif
   end

endmodule

// File: tb/tb_regfile_pred.sv
// ---------------------------------------------------------------------------
// tb_regfile_pred
// Directed bench for regfile_pred. Expected values are hand-computed; the
// ones that differ between the default and REGFILE_BYPASS_EN builds are
// selected through the BYP constant.
// ---------------------------------------------------------------------------
module tb_regfile_pred;

`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clk;
   logic rst_n;

   int checks   = 0;
   int failures = 0;

   regfile_pred_if bus ();

   regfile_pred dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.claim_valid = 1'b0;
      bus.claim_addr  = '0;
      bus.wr_en       = 1'b0;
      bus.wr_addr     = '0;
      bus.wr_data     = '0;
   endtask

   initial begin
      rst_n         = 1'b0;
      bus.pred_addr = '0;
      bus.rs_addr   = '0;
      bus.rt_addr   = '0;
      idle();

      // ---- reset held: writes and claims must have no visible effect ----
      #2;
      bus.wr_en       = 1'b1;
      bus.wr_addr     = 4'd1;
      bus.wr_data     = 32'hFFFF_FFFF;
      bus.rs_addr     = 4'd1;
      bus.pred_addr   = 4'd1;
      bus.claim_valid = 1'b1;
      bus.claim_addr  = 4'd1;
      #1;
      $display("txn reset-held write/claim r1");
      chk("rst_rs_r1", bus.rs_value, 32'h0);
      chk("rst_pred_busy", {31'b0, bus.pred_busy}, 32'h0);
      chk("rst_claim_ready", {31'b0, bus.claim_ready}, 32'h1);
      tick();
      chk("rst_rs_r1_after_edge", bus.rs_value, 32'h0);
      idle();
      rst_n = 1'b1;
      #1;

      // ---- all registers zero, nothing busy ----
      for (int i = 0; i < 16; i++) begin
         bus.rs_addr    = 4'(i);
         bus.rt_addr    = 4'(15 - i);
         bus.pred_addr  = 4'(i);
         bus.claim_addr = 4'(i);
         #1;
         $display("txn read-after-reset r%0d", i);
         chk($sformatf("init_rs_r%0d", i), bus.rs_value, 32'h0);
         chk($sformatf("init_rt_r%0d", 15 - i), bus.rt_value, 32'h0);
         chk($sformatf("init_pred_r%0d", i), bus.pred_value, 32'h0);
         chk($sformatf("init_busy_r%0d", i), {31'b0, bus.pred_busy}, 32'h0);
         chk($sformatf("init_ready_r%0d", i), {31'b0, bus.claim_ready}, 32'h1);
      end
      tick();

      // ---- write r5 ----
      bus.wr_en     = 1'b1;
      bus.wr_addr   = 4'd5;
      bus.wr_data   = 32'hDEAD_BEEF;
      bus.pred_addr = 4'd5;
      #1;
      $display("txn write r5=0xdeadbeef");
      chk("r5_same_cycle", bus.pred_value, BYP ? 32'hDEAD_BEEF : 32'h0);
      tick();
      idle();
      #1;
      chk("r5_next_cycle", bus.pred_value, 32'hDEAD_BEEF);

      // ---- write r0 ignored ----
      bus.wr_en   = 1'b1;
      bus.wr_addr = 4'd0;
      bus.wr_data = 32'h0000_1234;
      bus.rs_addr = 4'd0;
      #1;
      $display("txn write r0=0x1234");
      chk("r0_same_cycle", bus.rs_value, 32'h0);
      tick();
      idle();
      #1;
      chk("r0_after", bus.rs_value, 32'h0);

      // ---- claim r3, re-claim stalls, write r3 retires ----
      bus.claim_valid = 1'b1;
      bus.claim_addr  = 4'd3;
      #1;
      $display("txn claim r3");
      chk("claim_r3_ready", {31'b0, bus.claim_ready}, 32'h1);
      tick();
      bus.claim_valid = 1'b0;
      bus.pred_addr   = 4'd3;
      #1;
      chk("r3_busy", {31'b0, bus.pred_busy}, 32'h1);
      bus.claim_valid = 1'b1;
      #1;
      $display("txn re-claim r3");
      chk("reclaim_r3_stall", {31'b0, bus.claim_ready}, 32'h0);
      tick();
      bus.claim_valid = 1'b0;
      #1;
      chk("r3_busy_after_stall", {31'b0, bus.pred_busy}, 32'h1);
      bus.wr_en   = 1'b1;
      bus.wr_addr = 4'd3;
      bus.wr_data = 32'd7;
      #1;
      $display("txn write r3=7");
      chk("r3_busy_in_write", {31'b0, bus.pred_busy}, BYP ? 32'h0 : 32'h1);
      chk("r3_ready_in_write", {31'b0, bus.claim_ready}, 32'h1);
      chk("r3_value_in_write", bus.pred_value, BYP ? 32'd7 : 32'h0);
      tick();
      idle();
      #1;
      chk("r3_busy_after_write", {31'b0, bus.pred_busy}, 32'h0);
      chk("r3_value_after_write", bus.pred_value, 32'd7);

      // ---- r4: claim and write collide, claim wins ----
      bus.claim_valid = 1'b1;
      bus.claim_addr  = 4'd4;
      $display("txn claim r4");
      tick();
      bus.wr_en     = 1'b1;
      bus.wr_addr   = 4'd4;
      bus.wr_data   = 32'd9;
      bus.pred_addr = 4'd4;
      #1;
      $display("txn claim r4 + write r4=9");
      chk("r4_ready_collide", {31'b0, bus.claim_ready}, 32'h1);
      chk("r4_busy_collide", {31'b0, bus.pred_busy}, BYP ? 32'h0 : 32'h1);
      tick();
      idle();
      bus.rs_addr = 4'd4;
      #1;
      chk("r4_busy_after", {31'b0, bus.pred_busy}, 32'h1);
      chk("r4_value_after", bus.rs_value, 32'd9);

      // ---- r6 forwarding ----
      bus.wr_en   = 1'b1;
      bus.wr_addr = 4'd6;
      bus.wr_data = 32'hA5A5_A5A5;
      bus.rs_addr = 4'd6;
      bus.rt_addr = 4'd5;
      #1;
      $display("txn write r6=0xa5a5a5a5");
      chk("r6_rs_same_cycle", bus.rs_value, BYP ? 32'hA5A5_A5A5 : 32'h0);
      chk("r5_rt_unaffected", bus.rt_value, 32'hDEAD_BEEF);
      tick();
      idle();
      #1;
      chk("r6_rs_after", bus.rs_value, 32'hA5A5_A5A5);

      // ---- claim r2 then reset mid-operation ----
      bus.claim_valid = 1'b1;
      bus.claim_addr  = 4'd2;
      $display("txn claim r2");
      tick();
      bus.claim_addr = 4'd7;
      bus.wr_en      = 1'b1;
      bus.wr_addr    = 4'd2;
      bus.wr_data    = 32'h0000_0066;
      bus.pred_addr  = 4'd2;
      bus.rs_addr    = 4'd2;
      #1;
      chk("r2_busy_before_rst", {31'b0, bus.pred_busy}, BYP ? 32'h0 : 32'h1);
      #1;
      rst_n = 1'b0;
      bus.claim_addr = 4'd4;
      #1;
      $display("txn async reset mid-operation");
      chk("rst_r2_busy", {31'b0, bus.pred_busy}, 32'h0);
      chk("rst_r2_value", bus.rs_value, 32'h0);
      chk("rst_r4_ready", {31'b0, bus.claim_ready}, 32'h1);
      bus.rt_addr = 4'd5;
      #1;
      chk("rst_r5_value", bus.rt_value, 32'h0);
      tick();
      idle();
      rst_n = 1'b1;
      bus.pred_addr = 4'd7;
      bus.rs_addr   = 4'd2;
      bus.rt_addr   = 4'd6;
      #1;
      chk("post_rst_r7_busy", {31'b0, bus.pred_busy}, 32'h0);
      chk("post_rst_r2_value", bus.rs_value, 32'h0);
      chk("post_rst_r6_value", bus.rt_value, 32'h0);
      bus.pred_addr = 4'd4;
      #1;
      chk("post_rst_r4_busy", {31'b0, bus.pred_busy}, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/regfile_pred.md
REGFILE_PRED -- requirements
Module: regfile_pred

Interface
REQ-001 Parameter: XLEN, 32, data width of every register.
REQ-002 Parameter: NREGS, 16, register count; addresses are 4 bits wide.
REQ-003 SHALL use one clock and asynchronous active-low reset: clk input 1 rising-edge clock; rst_n input 1 async active-low reset.
REQ-004 pred_addr input 4 predicate register select, from instr[31:28] of the decode predicate step.
REQ-005 pred_value output XLEN current value of pred_addr.
REQ-006 pred_busy output 1 pred_addr has an outstanding write claim.
REQ-007 rs_addr/rt_addr input 4 operand selects; rs_value/rt_value output XLEN operand values.
REQ-008 claim_valid input 1 and claim_addr input 4: decode reserves a destination register.
REQ-009 claim_ready output 1 claim accepted this cycle.
REQ-010 wr_en input 1, wr_addr input 4, wr_data input XLEN: writeback port.

Function
REQ-011 Reads SHALL be combinational from register storage; r0 SHALL always read 0.
REQ-012 A write with wr_en=1 and wr_addr!=0 SHALL update storage at the rising clk edge; writes to r0 SHALL be ignored.
REQ-013 Each register SHALL have a busy bit; r0 SHALL never be busy.
REQ-014 claim_ready SHALL be 1 when claim_addr==0 or busy[claim_addr]==0, or when a same-cycle write to claim_addr clears that bit; it SHALL be 0 otherwise (WAW stall).
REQ-015 A claim with claim_valid=1 and claim_ready=1 SHALL set busy[claim_addr] at the next edge; an unaccepted claim SHALL change no state.
REQ-016 A write SHALL clear busy[wr_addr] at the next edge.
REQ-017 When an accepted claim and a write target the same register in the same cycle, busy SHALL end set, because the claim wins.
REQ-018 pred_busy SHALL equal busy[pred_addr], masked by REQ-021 when the bypass is enabled.
REQ-019 A write to a register that is not busy SHALL still update storage; no error is flagged.

Reset
REQ-020 While rst_n=0, all registers SHALL be 0 and all busy bits clear; pred_busy=0, claim_ready=1, and all read outputs 0. Assertion mid-operation SHALL discard pending claims and the in-flight write.

Configuration
REQ-021 With REGFILE_BYPASS_EN defined:
- a read whose address equals an active wr_addr (!=0) SHALL return wr_data in the same cycle;
- pred_busy SHALL deassert in that cycle for the written register.
REQ-022 Without REGFILE_BYPASS_EN, reads SHALL return the old value and pred_busy SHALL stay 1 until the cycle after the write, giving one cycle more latency.

Structure
REQ-023 A shared package SHALL hold XLEN, the register address width, and the r0 index constant.
REQ-024 Busy tracking SHALL be one sub-module, reg_scoreboard: claim/clear inputs, busy vector out.

Verification
REQ-025 After reset, read all 16 registers -> every value 0, pred_busy=0, claim_ready=1.
REQ-026 Write r5=0xDEADBEEF, then pred_addr=5 next cycle -> pred_value=0xDEADBEEF; write r0=0x1234 -> r0 reads 0.
REQ-027 Claim r3, next cycle pred_addr=3 -> pred_busy=1; re-claim r3 -> claim_ready=0; write r3=7 -> pred_busy=0 one cycle later (same cycle with bypass).
REQ-028 Claim r4 and write r4=9 in the same cycle, r4 previously claimed -> busy stays set and r4 reads 9.
REQ-029 Bypass build: wr_en=1, wr_addr=6, wr_data=0xA5A5A5A5, with rs_addr=6 -> rs_value=0xA5A5A5A5 in the same cycle; non-bypass build -> old value.
REQ-030 Claim r2, then assert rst_n=0 mid-operation -> busy clears, r2 reads 0, claim_ready=1.
